// File: rtl/uart_responder.sv
// uart_responder
//   Receives a 32-bit word as four serial frames on rx (byte0 first), reports
//   per-byte framing/parity errors, then answers on tx with either the echoed
//   word or an error code {16'hBAD0, 12'h000, perr}. Half duplex: rx is ignored
//   while a response is being transmitted.
//
//   Optional build macro: UART_RESP_PARITY_EN
//     defined   -> 11-bit frames: start, 8 data LSB first, even parity, stop
//     undefined -> 10-bit frames: start, 8 data LSB first, stop; stop errors only
//
//   Parameters
//     CLKS_PER_BIT  clock cycles per serial bit (4..65535)
//     GAP_BITS      maximum idle bit-times allowed between bytes of one word
//   Ports
//     clk         single clock, rising edge
//     rst         asynchronous active-high reset
//     rx          serial input from the initiator, idle high
//     tx          serial response output, idle high
//     word_out    last complete word received, byte0 in [7:0]
//     word_valid  one-cycle pulse when word_out/perr update
//     perr        per-byte error flags of the last word (bit n = byte n)
//     gap_err     one-cycle pulse when a partial word is dropped on timeout
//     busy        high from the first confirmed start bit until the response ends
module uart_responder #(
   parameter int CLKS_PER_BIT = 8,
   parameter int GAP_BITS     = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic        tx,
   output logic [31:0] word_out,
   output logic        word_valid,
   output logic [3:0]  perr,
   output logic        gap_err,
   output logic        busy
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RX_START = 3'd1;
   localparam logic [2:0] RX_DATA  = 3'd2;
   localparam logic [2:0] RX_PAR   = 3'd3;
   localparam logic [2:0] RX_STOP  = 3'd4;
   localparam logic [2:0] RX_GAP   = 3'd5;
   localparam logic [2:0] TX_LOAD  = 3'd6;
   localparam logic [2:0] TX_SHIFT = 3'd7;

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [31:0] GAP_LAST  = 32'(GAP_BITS * CLKS_PER_BIT - 1);
`ifdef UART_RESP_PARITY_EN
   localparam logic [3:0]  FRAME_LAST = 4'd10;
`else
   localparam logic [3:0]  FRAME_LAST = 4'd9;
`endif

   function automatic logic even_par(input logic [7:0] data);
      return ^data;
   endfunction

   // Frame bits in transmit order, index 0 = start bit.
   function automatic logic [10:0] build_frame(input logic [7:0] data);
`ifdef UART_RESP_PARITY_EN
      return {1'b1, even_par(data), data, 1'b0};
`else
      return {1'b1, 1'b1, data, 1'b0};
`endif
   endfunction

   logic        rx_meta_r, rx_sync_r, rx_prev_r;
   logic        line_ready_r;
   logic [15:0] ready_cnt_r;
   logic [2:0]  state_r;
   logic [15:0] clk_cnt_r;
   logic [3:0]  bit_cnt_r;
   logic [1:0]  byte_cnt_r;
   logic [31:0] gap_cnt_r;
   logic [7:0]  rx_shift_r;
`ifdef UART_RESP_PARITY_EN
   logic        rx_par_r;
`endif
   logic [23:0] rx_word_r;
   logic [2:0]  perr_acc_r;
   logic [31:0] tx_word_r;
   logic        tx_r, word_valid_r, gap_err_r, busy_r;
   logic [31:0] word_out_r;
   logic [3:0]  perr_r;

   logic        start_edge_s, byte_err_s;
   logic [31:0] new_word_s, resp_word_s;
   logic [3:0]  new_perr_s;
   logic [7:0]  tx_byte_s;
   logic [10:0] tx_frame_s;

   // Start-edge detect, current byte error, and the word/response formed at the last stop bit.
   always_comb begin
      start_edge_s = rx_prev_r & ~rx_sync_r;
`ifdef UART_RESP_PARITY_EN
      byte_err_s   = ~rx_sync_r | (rx_par_r ^ even_par(rx_shift_r));
`else
      byte_err_s   = ~rx_sync_r;
`endif
      new_word_s   = {rx_shift_r, rx_word_r};
      new_perr_s   = {byte_err_s, perr_acc_r};
      if (new_perr_s == 4'b0000) begin
         resp_word_s = new_word_s;
      end else begin
         resp_word_s = {16'hBAD0, 12'h000, new_perr_s};
      end
      case (byte_cnt_r)
         2'd0:    tx_byte_s = tx_word_r[7:0];
         2'd1:    tx_byte_s = tx_word_r[15:8];
         2'd2:    tx_byte_s = tx_word_r[23:16];
         default: tx_byte_s = tx_word_r[31:24];
      endcase
      tx_frame_s = build_frame(tx_byte_s);
   end

   // rx synchronizer, edge history, and one bit-time of idle line required after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_r    <= 1'b1;
         rx_sync_r    <= 1'b1;
         rx_prev_r    <= 1'b1;
         line_ready_r <= 1'b0;
         ready_cnt_r  <= 16'd0;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= rx_sync_r;
         if (!line_ready_r) begin
            if (!rx_sync_r) begin
               ready_cnt_r <= 16'd0;
            end else if (ready_cnt_r == BIT_LAST) begin
               line_ready_r <= 1'b1;
            end else begin
               ready_cnt_r <= ready_cnt_r + 16'd1;
            end
         end
      end
   end

   // Receive/transmit state machine with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         clk_cnt_r    <= 16'd0;
         bit_cnt_r    <= 4'd0;
         byte_cnt_r   <= 2'd0;
         gap_cnt_r    <= 32'd0;
         rx_shift_r   <= 8'd0;
`ifdef UART_RESP_PARITY_EN
         rx_par_r     <= 1'b0;
`endif
         rx_word_r    <= 24'd0;
         perr_acc_r   <= 3'd0;
         tx_word_r    <= 32'd0;
         tx_r         <= 1'b1;
         word_out_r   <= 32'd0;
         word_valid_r <= 1'b0;
         perr_r       <= 4'd0;
         gap_err_r    <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         word_valid_r <= 1'b0;
         gap_err_r    <= 1'b0;
         case (state_r)
            IDLE: begin
               tx_r <= 1'b1;
               if (start_edge_s && line_ready_r) begin
                  state_r    <= RX_START;
                  clk_cnt_r  <= 16'd0;
                  byte_cnt_r <= 2'd0;
                  rx_word_r  <= 24'd0;
                  perr_acc_r <= 3'd0;
               end
            end
            RX_START: begin
               if (clk_cnt_r == HALF_LAST) begin
                  clk_cnt_r <= 16'd0;
                  if (rx_sync_r) begin
                     // Line back high at mid-bit: a glitch, drop everything quietly.
                     state_r    <= IDLE;
                     byte_cnt_r <= 2'd0;
                     busy_r     <= 1'b0;
                  end else begin
                     state_r   <= RX_DATA;
                     bit_cnt_r <= 4'd0;
                     busy_r    <= 1'b1;
                  end
               end else begin
                  clk_cnt_r <= clk_cnt_r + 16'd1;
               end
            end
            RX_DATA: begin
               if (clk_cnt_r == BIT_LAST) begin
                  clk_cnt_r  <= 16'd0;
                  rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                  if (bit_cnt_r == 4'd7) begin
                     bit_cnt_r <= 4'd0;
`ifdef UART_RESP_PARITY_EN
                     state_r   <= RX_PAR;
`else
                     state_r   <= RX_STOP;
`endif
                  end else begin
                     bit_cnt_r <= bit_cnt_r + 4'd1;
                  end
               end else begin
                  clk_cnt_r <= clk_cnt_r + 16'd1;
               end
            end
            RX_PAR: begin
`ifdef UART_RESP_PARITY_EN
               if (clk_cnt_r == BIT_LAST) begin
                  clk_cnt_r <= 16'd0;
                  rx_par_r  <= rx_sync_r;
                  state_r   <= RX_STOP;
               end else begin
                  clk_cnt_r <= clk_cnt_r + 16'd1;
               end
`else
               state_r <= IDLE;
               busy_r  <= 1'b0;
`endif
            end
            RX_STOP: begin
               if (clk_cnt_r == BIT_LAST) begin
                  clk_cnt_r <= 16'd0;
                  if (byte_cnt_r == 2'd3) begin
                     word_out_r   <= new_word_s;
                     perr_r       <= new_perr_s;
                     word_valid_r <= 1'b1;
                     tx_word_r    <= resp_word_s;
                     byte_cnt_r   <= 2'd0;
                     state_r      <= TX_LOAD;
                  end else begin
                     case (byte_cnt_r)
                        2'd0: begin
                           rx_word_r[7:0] <= rx_shift_r;
                           perr_acc_r[0]  <= byte_err_s;
                        end
                        2'd1: begin
                           rx_word_r[15:8] <= rx_shift_r;
                           perr_acc_r[1]   <= byte_err_s;
                        end
                        default: begin
                           rx_word_r[23:16] <= rx_shift_r;
                           perr_acc_r[2]    <= byte_err_s;
                        end
                     endcase
                     byte_cnt_r <= byte_cnt_r + 2'd1;
                     gap_cnt_r  <= 32'd0;
                     state_r    <= RX_GAP;
                  end
               end else begin
                  clk_cnt_r <= clk_cnt_r + 16'd1;
               end
            end
            RX_GAP: begin
               if (start_edge_s) begin
                  state_r   <= RX_START;
                  clk_cnt_r <= 16'd0;
               end else if (gap_cnt_r == GAP_LAST) begin
                  gap_err_r  <= 1'b1;
                  busy_r     <= 1'b0;
                  byte_cnt_r <= 2'd0;
                  state_r    <= IDLE;
               end else begin
                  gap_cnt_r <= gap_cnt_r + 32'd1;
               end
            end
            TX_LOAD: begin
               // Start bit goes out on the cycle right after word_valid.
               tx_r       <= 1'b0;
               clk_cnt_r  <= 16'd0;
               bit_cnt_r  <= 4'd0;
               byte_cnt_r <= 2'd0;
               state_r    <= TX_SHIFT;
            end
            TX_SHIFT: begin
               if (clk_cnt_r == BIT_LAST) begin
                  clk_cnt_r <= 16'd0;
                  if (bit_cnt_r == FRAME_LAST) begin
                     if (byte_cnt_r == 2'd3) begin
                        tx_r       <= 1'b1;
                        busy_r     <= 1'b0;
                        byte_cnt_r <= 2'd0;
                        state_r    <= IDLE;
                     end else begin
                        // Next start bit follows the stop bit with no idle time.
                        tx_r       <= 1'b0;
                        bit_cnt_r  <= 4'd0;
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                     end
                  end else begin
                     tx_r      <= tx_frame_s[bit_cnt_r + 4'd1];
                     bit_cnt_r <= bit_cnt_r + 4'd1;
                  end
               end else begin
                  clk_cnt_r <= clk_cnt_r + 16'd1;
               end
            end
            default: begin
               state_r <= IDLE;
               tx_r    <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign tx         = tx_r;
   assign word_out   = word_out_r;
   assign word_valid = word_valid_r;
   assign perr       = perr_r;
   assign gap_err    = gap_err_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_uart_responder.sv
`timescale 1ns/1ps
module tb_uart_responder;
   localparam int CPB = 8;
   localparam int GAP = 20;
`ifdef UART_RESP_PARITY_EN
   localparam int FL     = 11;
   localparam bit PAR_EN = 1'b1;
`else
   localparam int FL     = 10;
   localparam bit PAR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic        tx;
   logic [31:0] word_out;
   logic        word_valid;
   logic [3:0]  perr;
   logic        gap_err;
   logic        busy;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   uart_responder #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
      .clk(clk), .rst(rst), .rx(rx), .tx(tx), .word_out(word_out),
      .word_valid(word_valid), .perr(perr), .gap_err(gap_err), .busy(busy)
   );

   typedef struct packed {
      logic [31:0] word;
      logic [3:0]  perr;
   } rx_exp_t;

   rx_exp_t     exp_rx[$];
   logic [31:0] exp_tx[$];
   rx_exp_t     e;
   int          gap_seen = 0;
   int          words_seen = 0;
   int          tx_words = 0;
   int          cyc = 0;
   int          wv_cyc = 0;
   bit          wv_prev = 1'b0;
   logic [31:0] last_tx_word = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: what the responder must report and send back for a word with injected faults.
   task automatic expect_word(input logic [31:0] w, input logic [3:0] bad_par, input logic [3:0] bad_stop);
      rx_exp_t x;
      x.word = w;
      x.perr = bad_stop | (PAR_EN ? bad_par : 4'b0000);
      exp_rx.push_back(x);
      exp_tx.push_back((x.perr == 4'b0000) ? w : {16'hBAD0, 12'h000, x.perr});
   endtask

   always @(posedge clk) cyc++;

   // Per-cycle comparison of the receive-side outputs and idle-line behaviour.
   always @(negedge clk) begin
      if (rst) begin
         wv_prev = 1'b0;
      end else begin
         if (wv_prev) check("tx_start_latency", 32'(tx), 32'd0);
         if (word_valid) begin
            words_seen++;
            wv_cyc = cyc;
            if (exp_rx.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("FAIL unexpected_word_valid: word_out %h, none expected", word_out);
            end else begin
               e = exp_rx.pop_front();
               check("word_out", word_out, e.word);
               check("perr", 32'(perr), 32'(e.perr));
            end
         end
         if (gap_err) gap_seen++;
         if (!busy) check("tx_idle_high", 32'(tx), 32'd1);
         wv_prev = word_valid;
      end
   end

   // Serial decoder for tx: one word is 4*FL bit-times sampled at mid-bit, back to back.
   bit          mon_act = 1'b0;
   int          mon_cnt = 0;
   int          mon_k;
   logic [10:0] mon_fr;
   logic [31:0] mon_word;
   always @(negedge clk) begin
      if (rst) begin
         mon_act = 1'b0;
      end else if (!mon_act) begin
         if (tx == 1'b0) begin
            mon_act = 1'b1;
            mon_cnt = 0;
         end
      end else begin
         mon_cnt++;
      end
      if (mon_act && !rst && (mon_cnt % CPB) == CPB / 2) begin
         mon_k = mon_cnt / CPB;
         mon_fr[mon_k % FL] = tx;
         if ((mon_k % FL) == FL - 1) begin
            check("tx_start_bit", 32'(mon_fr[0]), 32'd0);
            check("tx_stop_bit", 32'(mon_fr[FL-1]), 32'd1);
`ifdef UART_RESP_PARITY_EN
            check("tx_parity", 32'(mon_fr[9]), 32'(^mon_fr[8:1]));
`endif
            mon_word[8*(mon_k/FL) +: 8] = mon_fr[8:1];
            if (mon_k / FL == 3) begin
               mon_act = 1'b0;
               tx_words++;
               last_tx_word = mon_word;
               if (exp_tx.size() == 0) begin
                  tests_run++;
                  tests_failed++;
                  $display("FAIL unexpected_response: tx word %h, none expected", mon_word);
               end else begin
                  check("tx_word", mon_word, exp_tx.pop_front());
               end
            end
         end
      end
   end

   task automatic hold_bits(input logic v, input int n);
      rx = v;
      repeat (n * CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      hold_bits(1'b0, 1);
      for (int i = 0; i < 8; i++) hold_bits(b[i], 1);
`ifdef UART_RESP_PARITY_EN
      hold_bits(^b ^ bad_par, 1);
`endif
      hold_bits(~bad_stop, 1);
   endtask

   task automatic send_word(input logic [31:0] w, input logic [3:0] bad_par, input logic [3:0] bad_stop);
      expect_word(w, bad_par, bad_stop);
      for (int n = 0; n < 4; n++) begin
         send_frame(w[8*n +: 8], bad_par[n], bad_stop[n]);
         if (n < 3) hold_bits(1'b1, 1);
      end
   endtask

   task automatic wait_idle(input string name);
      int k;
      for (k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (!busy && !mon_act && exp_tx.size() == 0) break;
      end
      tests_run++;
      if (k >= 3000) begin
         tests_failed++;
         $display("FAIL %s_timeout: busy %0d, %0d responses outstanding", name, busy, exp_tx.size());
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int words_before;
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_word_out", word_out, 32'd0);
      check("rst_word_valid", 32'(word_valid), 32'd0);
      check("rst_perr", 32'(perr), 32'd0);
      check("rst_gap_err", 32'(gap_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      hold_bits(1'b1, 2);

      // Clean word echoed back.
      send_word(32'h1234_5678, 4'b0000, 4'b0000);
      wait_idle("echo");
      check("echo_word_out", word_out, 32'h1234_5678);
      check("echo_perr", 32'(perr), 32'd0);
      check("echo_tx_word", last_tx_word, 32'h1234_5678);
      check("echo_count", 32'(tx_words), 32'd1);

      // Byte2 parity flipped.
      send_word(32'hA5A5_A5A5, 4'b0100, 4'b0000);
      wait_idle("parity");
`ifdef UART_RESP_PARITY_EN
      check("parity_perr", 32'(perr), 32'h4);
      check("parity_tx_word", last_tx_word, 32'hBAD0_0004);
`else
      check("parity_perr", 32'(perr), 32'h0);
      check("parity_tx_word", last_tx_word, 32'hA5A5_A5A5);
`endif

      // Byte0 stop bit low.
      send_word(32'hDEAD_BEEF, 4'b0000, 4'b0001);
      wait_idle("stop");
      check("stop_perr", 32'(perr), 32'h1);
      check("stop_tx_word", last_tx_word, 32'hBAD0_0001);
      check("stop_word_out", word_out, 32'hDEAD_BEEF);

      // Two bytes then a long idle line.
      words_before = words_seen;
      send_frame(8'h11, 1'b0, 1'b0);
      check("gap_busy_during", 32'(busy), 32'd1);
      hold_bits(1'b1, 1);
      send_frame(8'h22, 1'b0, 1'b0);
      hold_bits(1'b1, GAP + 1);
      check("gap_err_count", 32'(gap_seen), 32'd1);
      check("gap_no_word", 32'(words_seen), 32'(words_before));
      check("gap_word_out", word_out, 32'hDEAD_BEEF);
      check("gap_busy_after", 32'(busy), 32'd0);
      check("gap_tx_count", 32'(tx_words), 32'd3);

      // Short low glitch on an idle line.
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      for (int i = 0; i < 2 * CPB; i++) begin
         @(negedge clk);
         check("glitch_busy", 32'(busy), 32'd0);
      end
      check("glitch_no_word", 32'(words_seen), 32'(words_before));
      check("glitch_no_gap", 32'(gap_seen), 32'd1);

      // Reset in the middle of response byte1 (byte1 = 8'h00, so tx is low there).
      words_before = words_seen;
      send_word(32'h1100_0000, 4'b0000, 4'b0000);
      check("rst_case_word_seen", 32'(words_seen), 32'(words_before + 1));
      for (int k = 0; k < 1000 && cyc < wv_cyc + 1 + FL * CPB + 3 * CPB + CPB / 2; k++) @(negedge clk);
      check("pre_rst_tx_low", 32'(tx), 32'd0);
      check("pre_rst_busy", 32'(busy), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_tx", 32'(tx), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_word_out", word_out, 32'd0);
      exp_tx.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      hold_bits(1'b1, 2);
      send_word(32'h0000_00FF, 4'b0000, 4'b0000);
      wait_idle("post_rst");
      check("post_rst_word_out", word_out, 32'h0000_00FF);
      check("post_rst_perr", 32'(perr), 32'd0);
      check("post_rst_tx_word", last_tx_word, 32'h0000_00FF);

      check("left_rx_expect", 32'(exp_rx.size()), 32'd0);
      check("left_tx_expect", 32'(exp_tx.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
